// File: rtl/training_sequencer.sv
// Sequences one training run: for each epoch it fetches every sample, waits for the
// datapath to settle, then issues one weight-commit step. The ratio halves every DECAY_EPOCHS epochs.
module training_sequencer #(
  parameter int SAMPLE_AW     = 6,
  parameter int SETTLE_CYCLES = 4,
  parameter int DECAY_EPOCHS  = 8
) (
  input  logic                 ts_clock,
  input  logic                 ts_reset_n,
  input  logic                 ts_start,
  input  logic                 ts_abort,
  input  logic [SAMPLE_AW:0]   ts_num_samples,
  input  logic [15:0]          ts_num_epochs,
  input  logic [15:0]          ts_ratio_init,
  output logic                 ts_sample_req,
  output logic [SAMPLE_AW-1:0] ts_sample_addr,
  input  logic                 ts_sample_ack,
  output logic                 ts_neuron_step,
  output logic [15:0]          ts_training_ratio,
  output logic [15:0]          ts_epoch,
  output logic                 ts_busy,
  output logic                 ts_done,
  output logic [2:0]           ts_dbg_state
);

  localparam int DW = (DECAY_EPOCHS > 1) ? $clog2(DECAY_EPOCHS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETTLE = 3'd2,
    S_COMMIT = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Sample memory handshake: ts_sample_req rises on entry to FETCH and holds, with a
  // stable address, until the first cycle ts_sample_ack is high; ack is ignored elsewhere.
  state_t               r_state;
  logic                 r_ready;
  logic [SAMPLE_AW:0]   r_num_samples;
  logic [15:0]          r_num_epochs;
  logic [7:0]           r_settle_cnt;
  logic [DW-1:0]        r_decay_cnt;
  logic                 r_req;
  logic [SAMPLE_AW-1:0] r_addr;
  logic                 r_step;
  logic [15:0]          r_ratio;
  logic [15:0]          r_epoch;
  logic                 r_busy;
  logic                 r_done;

  logic w_last_sample;
  logic w_last_epoch;
  logic w_decay_hit;

  assign w_last_sample = ({1'b0, r_addr} == (r_num_samples - {{SAMPLE_AW{1'b0}}, 1'b1}));
  assign w_last_epoch  = ((r_epoch + 16'd1) == r_num_epochs);
  assign w_decay_hit   = (r_decay_cnt == DW'(DECAY_EPOCHS - 1));

  // r_ready delays start acceptance until the second edge after reset release.
  always_ff @(posedge ts_clock or negedge ts_reset_n) begin
    if (!ts_reset_n) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b0;
      r_num_samples <= '0;
      r_num_epochs  <= '0;
      r_settle_cnt  <= '0;
      r_decay_cnt   <= '0;
      r_req         <= 1'b0;
      r_addr        <= '0;
      r_step        <= 1'b0;
      r_ratio       <= '0;
      r_epoch       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
      if (ts_abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_req   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ts_start && r_ready) begin
              if ((ts_num_samples != '0) && (ts_num_epochs != '0)) begin
                r_num_samples <= ts_num_samples;
                r_num_epochs  <= ts_num_epochs;
                r_ratio       <= ts_ratio_init;
                r_addr        <= '0;
                r_epoch       <= '0;
                r_decay_cnt   <= '0;
                r_req         <= 1'b1;
                r_busy        <= 1'b1;
                r_state       <= S_FETCH;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (ts_sample_ack) begin
              r_req        <= 1'b0;
              r_settle_cnt <= 8'(SETTLE_CYCLES - 1);
              r_state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_settle_cnt == 8'd0) r_state <= S_COMMIT;
            else                      r_settle_cnt <= r_settle_cnt - 8'd1;
          end
          S_COMMIT: begin
            r_step  <= 1'b1;
            r_state <= S_NEXT;
          end
          S_NEXT: begin
            if (!w_last_sample) begin
              r_addr  <= r_addr + 1'b1;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_addr <= '0;
              if (w_last_epoch) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_epoch <= r_epoch + 16'd1;
                r_req   <= 1'b1;
                r_state <= S_FETCH;
                if (w_decay_hit) begin
                  r_decay_cnt <= '0;
                  r_ratio     <= r_ratio >> 1;
                end else begin
                  r_decay_cnt <= r_decay_cnt + 1'b1;
                end
              end
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ts_sample_req     = r_req;
  assign ts_sample_addr    = r_addr;
  assign ts_neuron_step    = r_step;
  assign ts_training_ratio = r_ratio;
  assign ts_epoch          = r_epoch;
  assign ts_busy           = r_busy;
  assign ts_done           = r_done;
  assign ts_dbg_state      = r_state;

endmodule

// File: tb/tb_training_sequencer.sv
// Bench for training_sequencer: a sample-memory responder plus a scoreboard of expected
// (epoch, ratio, addr) tuples compared at every neuron step.
module tb_training_sequencer;

  localparam int AW     = 6;
  localparam int SETTLE = 4;
  localparam int DECAY  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ack = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic [15:0]   num_epochs = '0;
  logic [15:0]   ratio_init = '0;
  logic          req;
  logic [AW-1:0] addr;
  logic          step;
  logic [15:0]   ratio;
  logic [15:0]   epoch;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  training_sequencer #(
    .SAMPLE_AW    (AW),
    .SETTLE_CYCLES(SETTLE),
    .DECAY_EPOCHS (DECAY)
  ) dut (
    .ts_clock         (clk),
    .ts_reset_n       (rst_n),
    .ts_start         (start),
    .ts_abort         (abort),
    .ts_num_samples   (num_samples),
    .ts_num_epochs    (num_epochs),
    .ts_ratio_init    (ratio_init),
    .ts_sample_req    (req),
    .ts_sample_addr   (addr),
    .ts_sample_ack    (ack),
    .ts_neuron_step   (step),
    .ts_training_ratio(ratio),
    .ts_epoch         (epoch),
    .ts_busy          (busy),
    .ts_done          (done),
    .ts_dbg_state     (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard state
  logic [47:0]   exp_q[$];
  logic [47:0]   exp_ent;
  logic [AW-1:0] held_addr;
  int ack_delay = 0;
  int wait_cnt  = 0;
  int ack_cyc   = 0;
  int last_step = -1;
  int exp_gap   = SETTLE + 3;
  int step_cnt  = 0;
  int done_cnt  = 0;
  int req_total = 0;

  // sample memory responder and step/done monitor
  always @(negedge clk) begin
    ack = 1'b0;
    if (req) begin
      req_total++;
      if (wait_cnt == 0) held_addr = addr;
      else check("addr_hold", 32'(addr), 32'(held_addr));
      if (wait_cnt == ack_delay) begin
        ack      = 1'b1;
        ack_cyc  = cyc;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (step) begin
      step_cnt++;
      if (exp_q.size() == 0) begin
        check("step_unexpected", 32'd1, 32'd0);
      end else begin
        exp_ent = exp_q.pop_front();
        check("step_epoch", 32'(epoch), 32'(exp_ent[47:32]));
        check("step_ratio", 32'(ratio), 32'(exp_ent[31:16]));
        check("step_addr", 32'(addr), 32'(exp_ent[15:0]));
        check("ack_to_step", 32'(cyc - ack_cyc), 32'(SETTLE + 2));
        if (last_step >= 0) check("step_gap", 32'(cyc - last_step), 32'(exp_gap));
      end
      last_step = cyc;
    end
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic model_run(input int ns, input int ne, input logic [15:0] r0);
    logic [15:0] r;
    r = r0;
    for (int e = 0; e < ne; e++) begin
      for (int a = 0; a < ns; a++) exp_q.push_back({16'(e), r, 16'(a)});
      if ((e + 1 < ne) && (((e + 1) % DECAY) == 0)) r = r >> 1;
    end
  endtask

  task automatic pulse_start(input int ns, input int ne, input logic [15:0] r0);
    num_samples = (AW+1)'(ns);
    num_epochs  = 16'(ne);
    ratio_init  = r0;
    last_step   = -1;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    num_samples = (AW+1)'($urandom_range(0, 127));
    num_epochs  = 16'($urandom_range(0, 65535));
    ratio_init  = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while ((done_cnt == d0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 32'(req), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_ratio", 32'(ratio), 32'd0);
    check("rst_epoch", 32'(epoch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int s0;
    int d0;
    int r0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    release_reset();

    // nominal: 3 samples x 2 epochs, ack in the request cycle
    s0 = step_cnt;
    model_run(3, 2, 16'h8000);
    pulse_start(3, 2, 16'h8000);
    wait_done(200, "nom_done");
    check("nom_steps", 32'(step_cnt - s0), 32'd6);
    check("nom_epoch", 32'(epoch), 32'd1);
    check("nom_ratio", 32'(ratio), 32'h8000);
    @(negedge clk);
    check("nom_busy_after", 32'(busy), 32'd0);
    check("nom_done_1cyc", 32'(done), 32'd0);

    // decay: ratio halves every 2 epochs
    s0 = step_cnt;
    model_run(1, 5, 16'h8000);
    pulse_start(1, 5, 16'h8000);
    wait_done(200, "decay_done");
    check("decay_steps", 32'(step_cnt - s0), 32'd5);
    check("decay_ratio", 32'(ratio), 32'h2000);
    check("decay_epoch", 32'(epoch), 32'd4);
    @(negedge clk);

    // backpressure: ack 5 cycles late
    ack_delay = 5;
    exp_gap   = SETTLE + 3 + 5;
    s0 = step_cnt;
    r0 = req_total;
    model_run(2, 1, 16'h1234);
    pulse_start(2, 1, 16'h1234);
    wait_done(200, "bp_done");
    check("bp_steps", 32'(step_cnt - s0), 32'd2);
    check("bp_req_cycles", 32'(req_total - r0), 32'd12);
    ack_delay = 0;
    exp_gap   = SETTLE + 3;
    @(negedge clk);

    // abort during COMMIT of the first sample
    s0 = step_cnt;
    d0 = done_cnt;
    pulse_start(2, 1, 16'h1000);
    repeat (SETTLE + 1) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_step", 32'(step), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req", 32'(req), 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_step", 32'(step_cnt - s0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // zero epochs: done one cycle later, no request, no step
    s0 = step_cnt;
    r0 = req_total;
    pulse_start(3, 0, 16'h2222);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("zero_done_1cyc", 32'(done), 32'd0);
    repeat (10) @(negedge clk);
    check("zero_no_req", 32'(req_total - r0), 32'd0);
    check("zero_no_step", 32'(step_cnt - s0), 32'd0);

    // reset asserted in SETTLE of the second sample
    exp_q.push_back({16'd0, 16'h4444, 16'd0});
    pulse_start(3, 1, 16'h4444);
    repeat (SETTLE + 3 + 2) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    release_reset();
    check("mid_q_empty", 32'(exp_q.size()), 32'd0);
    s0 = step_cnt;
    model_run(2, 1, 16'h0100);
    pulse_start(2, 1, 16'h0100);
    wait_done(200, "rerun_done");
    check("rerun_steps", 32'(step_cnt - s0), 32'd2);

    repeat (3) @(negedge clk);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/training_sequencer.md
TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 The block SHALL have parameter SAMPLE_AW, default 6: width of the sample address.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4, legal range 1..255: cycles waited after sample fetch for the neuron and back-propagation datapath to settle.
REQ-003 The block SHALL have parameter DECAY_EPOCHS, default 8, legal range 1 or more: the training ratio halves every DECAY_EPOCHS completed epochs.
REQ-004 The block SHALL have a single clock and an asynchronous, active-low reset; the clock and reset ports SHALL be the first two ports, listed below.
REQ-005 ts_clock  in  1  the single clock; all state updates on its rising edge.
REQ-006 ts_reset_n  in  1  asynchronous, active-low reset.
REQ-007 ts_start  in  1  one-cycle pulse that starts a training run.
REQ-008 ts_abort  in  1  terminates the current run.
REQ-009 ts_num_samples  in  SAMPLE_AW+1  number of samples per epoch.
REQ-010 ts_num_epochs  in  16  number of epochs to run.
REQ-011 ts_ratio_init  in  16  initial training ratio, unsigned Q0.16.
REQ-012 ts_sample_req  out  1  request to the sample memory.
REQ-013 ts_sample_addr  out  SAMPLE_AW  address of the requested sample.
REQ-014 ts_sample_ack  in  1  sample memory has presented the dendrite and target data.
REQ-015 ts_neuron_step  out  1  one-cycle weight-commit strobe, used by the wrapper as the learning neuron clock edge.
REQ-016 ts_training_ratio  out  16  current ratio, Q0.16.
REQ-017 ts_epoch  out  16  index of the current epoch.
REQ-018 ts_busy  out  1  high in any state other than IDLE.
REQ-019 ts_done  out  1  one-cycle pulse at normal completion.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, FETCH, SETTLE, COMMIT, NEXT and DONE.
REQ-021 In IDLE, on ts_start with both counts nonzero: latch ts_num_samples, ts_num_epochs and ts_ratio_init; set addr=0, epoch=0, ratio=init; go to FETCH.
REQ-022 In IDLE, on ts_start with either count zero: pulse ts_done on the next cycle; stay IDLE; issue no request or step.
REQ-023 While busy, ts_start SHALL be ignored, and the count and ratio inputs SHALL be sampled only at an accepted start.
REQ-024 In FETCH, ts_sample_req=1 with a stable ts_sample_addr until ts_sample_ack is seen; on the ack cycle, go to SETTLE and load counter=SETTLE_CYCLES-1.
REQ-025 ts_sample_req SHALL be low in every cycle outside FETCH.
REQ-026 ts_sample_ack SHALL be ignored outside FETCH.
REQ-027 In SETTLE, the counter decrements each cycle; when it reaches 0, go to COMMIT.
REQ-028 In COMMIT, ts_neuron_step=1 for exactly one cycle; then go to NEXT.
REQ-029 In NEXT, if addr is below num_samples-1: addr+1, then FETCH.
REQ-030 In NEXT, if addr equals num_samples-1: addr wraps to 0 and the epoch completes.
REQ-031 On an epoch completion where epoch+1 equals num_epochs: go to DONE with ts_epoch unchanged.
REQ-032 On any other epoch completion: epoch+1, then FETCH; if (epoch+1) mod DECAY_EPOCHS is 0, ratio becomes ratio>>1 (logical shift, floor, reaching 0 permitted).
REQ-033 In DONE, ts_done=1 for one cycle; then IDLE.
REQ-034 In IDLE, ts_epoch and ts_training_ratio SHALL hold their final values until the next accepted start.
REQ-035 ts_abort in any non-IDLE state: IDLE next cycle, no ts_done, no pending request.
REQ-036 ts_abort during COMMIT SHALL suppress ts_neuron_step in that cycle.
REQ-037 ts_abort SHALL take priority over ts_sample_ack and over the settle counter.
REQ-038 Per-sample period SHALL be SETTLE_CYCLES+3+W cycles, where W is the number of FETCH cycles without ack.
REQ-039 All outputs SHALL be registered.

Reset
REQ-040 Asserting ts_reset_n low SHALL immediately force: state IDLE; ts_sample_req=0; ts_sample_addr=0; ts_neuron_step=0; ts_training_ratio=0; ts_epoch=0; ts_busy=0; ts_done=0.
REQ-041 Reset mid-run SHALL discard the run; there is no resume.
REQ-042 The first start SHALL be accepted on the second rising edge after reset deassertion.

Verification
REQ-043 Nominal run: samples=3, epochs=2, ratio=0x8000, ack same cycle as req -> addresses 0,1,2,0,1,2; 6 steps spaced 7 cycles apart; ts_epoch 0 then 1; one done; ratio stays 0x8000.
REQ-044 Decay: DECAY_EPOCHS=2, samples=1, epochs=5, ratio=0x8000 -> ratio 0x4000 at epoch 2 and 0x2000 at epoch 4; done after 5 steps.
REQ-045 Backpressure: ack delayed 5 cycles -> req and addr held stable for 6 cycles; step occurs SETTLE_CYCLES+2 cycles after ack.
REQ-046 Abort during COMMIT -> no step that cycle; IDLE next cycle; no done; ts_busy=0.
REQ-047 Zero epochs at start -> ts_done pulse one cycle later; req and step never asserted.
REQ-048 Reset asserted in SETTLE of sample 2 -> all outputs take their REQ-040 values asynchronously; the next start runs from addr 0.
